// File: rtl/neuron_seq_ctrl_pkg.sv
// Shared fixed-point format defaults and the sequencer state encoding for the
// neuron evaluation block.
package neuron_seq_ctrl_pkg;

  localparam int DEF_SIGN_BIT   = 1;
  localparam int DEF_INTE_WIDTH = 2;
  localparam int DEF_FRAC_WIDTH = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    OUT   = 2'd3
  } state_t;

endpackage

// File: rtl/neuron_mac_step.sv
// One multiply-accumulate step in Q(INTE).(FRAC): a*2^F + x*w at double width,
// then repacked to W bits with the double-width sign kept and magnitude wrapped.
module neuron_mac_step
  import neuron_seq_ctrl_pkg::*;
#(
  parameter int  SIGN_BIT   = DEF_SIGN_BIT,
  parameter int  INTE_WIDTH = DEF_INTE_WIDTH,
  parameter int  FRAC_WIDTH = DEF_FRAC_WIDTH,
  localparam int W          = SIGN_BIT + INTE_WIDTH + FRAC_WIDTH
)(
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] x,
  input  logic signed [W-1:0] w,
  output logic signed [W-1:0] y
);

  localparam int F = FRAC_WIDTH;
  localparam int I = INTE_WIDTH;

  logic signed [2*W-1:0] x_ext;
  logic signed [2*W-1:0] w_ext;
  logic signed [2*W-1:0] a_ext;
  logic signed [2*W-1:0] prod;
  logic signed [2*W-1:0] s;
  logic                  unused_bits;

  assign x_ext = x;
  assign w_ext = w;
  assign a_ext = a;
  assign prod  = x_ext * w_ext;
  assign s     = prod + (a_ext <<< F);

  // Sign comes from the top of the wide sum, not from the truncated field.
  assign y           = {s[2*W-1], s[2*F+I-1:2*F], s[2*F-1:F]};
  assign unused_bits = ^{s[2*W-2:2*F+I], s[F-1:0]};

endmodule

// File: rtl/neuron_seq_ctrl.sv
// Sequencer for one neuron: streams len x/w pairs from operand memory,
// accumulates them onto the bias, and presents the (optionally ReLU'd) result.
module neuron_seq_ctrl
  import neuron_seq_ctrl_pkg::*;
#(
  parameter int  SIGN_BIT   = DEF_SIGN_BIT,
  parameter int  INTE_WIDTH = DEF_INTE_WIDTH,
  parameter int  FRAC_WIDTH = DEF_FRAC_WIDTH,
  parameter int  ADDR_W     = 4,
  localparam int W          = SIGN_BIT + INTE_WIDTH + FRAC_WIDTH
)(
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [ADDR_W:0]     len,
  input  logic signed [W-1:0] bias,
  input  logic                relu_en,
  output logic                rd_en,
  output logic [ADDR_W-1:0]   rd_addr,
  input  logic signed [W-1:0] x_data,
  input  logic signed [W-1:0] w_data,
  output logic                busy,
  output logic                out_valid,
  input  logic                out_ready,
  output logic signed [W-1:0] result
);

  localparam logic [ADDR_W:0] N_MAX = {1'b1, {ADDR_W{1'b0}}};

  function automatic logic [ADDR_W:0] clamp_len(input logic [ADDR_W:0] l);
    return (l > N_MAX) ? N_MAX : l;
  endfunction

  function automatic logic signed [W-1:0] relu(input logic signed [W-1:0] v,
                                               input logic en);
    return (en && v[W-1]) ? '0 : v;
  endfunction

  state_t                state;
  state_t                state_nxt;
  logic [ADDR_W:0]       len_q;
  logic [ADDR_W:0]       len_m1;
  logic                  relu_q;
  logic [ADDR_W-1:0]     cnt;
  logic                  last;
  logic signed [W-1:0]   acc;
  logic signed [W-1:0]   acc_nxt;
  logic                  rd_vld_p1;

  assign len_m1 = len_q - (ADDR_W+1)'(1);
  assign last   = ({1'b0, cnt} == len_m1);

  neuron_mac_step #(
    .SIGN_BIT   (SIGN_BIT),
    .INTE_WIDTH (INTE_WIDTH),
    .FRAC_WIDTH (FRAC_WIDTH)
  ) u_step (
    .a (acc),
    .x (x_data),
    .w (w_data),
    .y (acc_nxt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (len != '0) ? RUN : OUT;
      RUN:     if (last) state_nxt = DRAIN;
      DRAIN:   state_nxt = OUT;
      OUT:     if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != IDLE);
    rd_en     = (state == RUN);
    rd_addr   = rd_en ? cnt : '0;
    out_valid = (state == OUT);
    result    = out_valid ? relu(acc, relu_q) : '0;
  end

  // Stage p0 -> p1: read strobe delayed to line up with the returning operands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_q     <= '0;
      relu_q    <= 1'b0;
      cnt       <= '0;
      acc       <= '0;
      rd_vld_p1 <= 1'b0;
    end else begin
      rd_vld_p1 <= (state == RUN);
      if (state == IDLE && start) begin
        len_q  <= clamp_len(len);
        relu_q <= relu_en;
        cnt    <= '0;
        acc    <= bias;
      end else begin
        if (state == RUN) cnt <= cnt + ADDR_W'(1);
        if (rd_vld_p1)    acc <= acc_nxt;
      end
    end
  end

endmodule

// File: tb/tb_neuron_seq_ctrl.sv
// Bench for neuron_seq_ctrl: directed vector table, reset-abort sequence and
// randomized evaluations against an integer-arithmetic reference model.
module tb_neuron_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [4:0] len;
  logic [7:0] bias;
  logic       relu_en;
  logic       rd_en;
  logic [3:0] rd_addr;
  logic [7:0] x_data;
  logic [7:0] w_data;
  logic       busy;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] result;

  logic [7:0] xmem [16];
  logic [7:0] wmem [16];

  int n_tests = 0;
  int n_fail  = 0;

  neuron_seq_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .len       (len),
    .bias      (bias),
    .relu_en   (relu_en),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .x_data    (x_data),
    .w_data    (w_data),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result)
  );

  always #5 clk = ~clk;

  // Operand memory: data appears one cycle after the strobe, garbage otherwise.
  always @(posedge clk) begin
    if (rd_en) begin
      x_data <= xmem[rd_addr];
      w_data <= wmem[rd_addr];
    end else begin
      x_data <= 8'($urandom);
      w_data <= 8'($urandom);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d", n_tests);
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: fixed-point values as integers; result keeps the true sign of
  // a*2^F + x*w and the low 7 bits of its floor division by 2^F.
  function automatic logic [7:0] ref_eval(input int l, input logic [7:0] b, input bit relu);
    int a, s, xi, wi, low7, n;
    n = (l > 16) ? 16 : l;
    a = $signed(b);
    for (int i = 0; i < n; i++) begin
      xi   = $signed(xmem[i]);
      wi   = $signed(wmem[i]);
      s    = a * 32 + xi * wi;
      low7 = (s >>> 5) & 127;
      a    = (s < 0) ? low7 - 128 : low7;
    end
    if (relu && a < 0) a = 0;
    return 8'(a);
  endfunction

  task automatic do_eval(input string tag, input int l, input logic [7:0] b,
                         input bit relu, input int hold, input logic [7:0] exp);
    int cyc, nrd, n_exp, lat_exp;
    bit seen;
    n_exp   = (l > 16) ? 16 : l;
    lat_exp = (n_exp == 0) ? 1 : n_exp + 2;
    @(negedge clk);
    len = 5'(l); bias = b; relu_en = relu; start = 1'b1; out_ready = (hold == 0);
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1; nrd = 0; seen = 0;
    while (cyc <= 40 && !seen) begin
      if (rd_en) begin
        check({tag, " rd_addr"}, 32'(rd_addr), 32'(nrd[3:0]));
        nrd++;
      end else begin
        check({tag, " rd_addr idle"}, 32'(rd_addr), 32'd0);
      end
      if (out_valid) seen = 1;
      else begin
        @(posedge clk); #1;
        cyc++;
      end
    end
    check({tag, " out_valid seen"}, 32'(seen), 32'd1);
    check({tag, " latency"}, 32'(cyc), 32'(lat_exp));
    check({tag, " read count"}, 32'(nrd), 32'(n_exp));
    check({tag, " result"}, 32'(result), 32'(exp));
    if (!seen) return;
    for (int k = 0; k < hold - 1; k++) begin
      start = (k == 0);
      @(posedge clk); #1;
      start = 1'b0;
      check({tag, " hold valid"}, 32'(out_valid), 32'd1);
      check({tag, " hold result"}, 32'(result), 32'(exp));
    end
    out_ready = 1'b1;
    start     = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, " idle after handshake"}, 32'(busy), 32'd0);
    check({tag, " valid after handshake"}, 32'(out_valid), 32'd0);
  endtask

  typedef struct {
    int         l;
    logic [7:0] b;
    bit         relu;
    logic [7:0] x0, x1, w0, w1;
    int         hold;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs [7];

  initial begin
    vecs[0] = '{2, 8'h08, 1'b0, 8'h20, 8'h10, 8'h20, 8'h40, 0, 8'h48};
    vecs[1] = '{0, 8'hF0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 8'hF0};
    vecs[2] = '{1, 8'h00, 1'b0, 8'h20, 8'h00, 8'hE0, 8'h00, 0, 8'hE0};
    vecs[3] = '{1, 8'h00, 1'b1, 8'h20, 8'h00, 8'hE0, 8'h00, 0, 8'h00};
    vecs[4] = '{1, 8'h00, 1'b0, 8'h60, 8'h00, 8'h60, 8'h00, 0, 8'h20};
    vecs[5] = '{2, 8'h08, 1'b0, 8'h20, 8'h10, 8'h20, 8'h40, 5, 8'h48};
    vecs[6] = '{0, 8'hF0, 1'b1, 8'h00, 8'h00, 8'h00, 8'h00, 2, 8'h00};

    rst = 1'b1; start = 1'b0; len = '0; bias = '0; relu_en = 1'b0; out_ready = 1'b1;
    x_data = '0; w_data = '0;
    for (int i = 0; i < 16; i++) begin xmem[i] = '0; wmem[i] = '0; end
    repeat (2) @(negedge clk);
    check("reset rd_en", 32'(rd_en), 32'd0);
    check("reset rd_addr", 32'(rd_addr), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset result", 32'(result), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      for (int j = 0; j < 16; j++) begin
        xmem[j] = 8'($urandom); wmem[j] = 8'($urandom);
      end
      xmem[0] = vecs[i].x0; xmem[1] = vecs[i].x1;
      wmem[0] = vecs[i].w0; wmem[1] = vecs[i].w1;
      do_eval($sformatf("vec%0d", i), vecs[i].l, vecs[i].b, vecs[i].relu,
              vecs[i].hold, vecs[i].exp);
    end

    // Abort a len=8 evaluation at its third read, then run a clean len=1 one.
    for (int j = 0; j < 16; j++) begin xmem[j] = 8'h20; wmem[j] = 8'h20; end
    @(negedge clk);
    len = 5'd8; bias = 8'h00; relu_en = 1'b0; start = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < 20 && !(rd_en && rd_addr == 4'd2); c++) begin
      @(posedge clk); #1;
    end
    check("abort reached third read", 32'(rd_en && rd_addr == 4'd2), 32'd1);
    #1 rst = 1'b1;
    #1;
    check("abort rd_en", 32'(rd_en), 32'd0);
    check("abort rd_addr", 32'(rd_addr), 32'd0);
    check("abort busy", 32'(busy), 32'd0);
    check("abort out_valid", 32'(out_valid), 32'd0);
    check("abort result", 32'(result), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    xmem[0] = 8'h20; wmem[0] = 8'h20;
    do_eval("post-reset", 1, 8'h08, 1'b0, 0, 8'h28);

    for (int r = 0; r < 24; r++) begin
      int         l;
      int         hold;
      logic [7:0] b;
      bit         relu;
      for (int j = 0; j < 16; j++) begin
        xmem[j] = 8'($urandom); wmem[j] = 8'($urandom);
      end
      l    = $urandom_range(0, 18);
      hold = $urandom_range(0, 3);
      b    = 8'($urandom);
      relu = 1'($urandom);
      do_eval($sformatf("rand%0d len%0d", r, l), l, b, relu, hold, ref_eval(l, b, relu));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/neuron_seq_ctrl.md
NEURON_SEQ_CTRL -- requirements
Module: neuron_seq_ctrl

Interface
REQ-001 Parameter SIGN_BIT, default 1, number of sign bits in the fixed-point format.
REQ-002 Parameter INTE_WIDTH, default 2, number of integer bits.
REQ-003 Parameter FRAC_WIDTH, default 5, number of fractional bits; data width W = SIGN_BIT+INTE_WIDTH+FRAC_WIDTH (8).
REQ-004 Parameter ADDR_W, default 4, operand-memory address width; N_MAX = 2**ADDR_W.
REQ-005 clk  in  1  single clock, all state updates on its rising edge.
REQ-006 rst  in  1  reset; asynchronous, active-high.
REQ-007 start  in  1  request a new neuron evaluation; sampled only in IDLE.
REQ-008 len  in  ADDR_W+1  number of x/w pairs (0..N_MAX); sampled with start.
REQ-009 bias  in  W  signed bias in Q(INTE).(FRAC); sampled with start.
REQ-010 relu_en  in  1  apply ReLU to the final result; sampled with start.
REQ-011 rd_en  out  1  operand-memory read strobe.
REQ-012 rd_addr  out  ADDR_W  operand-memory read address.
REQ-013 x_data  in  W  signed input value; valid exactly one cycle after rd_en.
REQ-014 w_data  in  W  signed weight value; valid exactly one cycle after rd_en.
REQ-015 busy  out  1  high whenever state is not IDLE.
REQ-016 out_valid  out  1  result is valid.
REQ-017 out_ready  in  1  consumer accepts the result.
REQ-018 result  out  W  signed neuron output.

Function
REQ-019 The FSM SHALL have four states: IDLE, RUN, DRAIN, OUT.
REQ-020 IDLE with start=1: latch len and relu_en, set acc=bias, cnt=0; go to RUN if len>0, otherwise go to OUT.
REQ-021 RUN: drive rd_en=1 and rd_addr=cnt, increment cnt; go to DRAIN after issuing address len-1.
REQ-022 The block SHALL keep a 1-bit read-valid pipeline; in every cycle where the previous cycle had rd_en=1, acc <= step(acc, x_data, w_data).
REQ-023 DRAIN: perform the final accumulate; go to OUT.
REQ-024 OUT: out_valid=1 and result=acc, or 0 if relu_en=1 and the sign bit of acc is 1; result is held stable while out_ready=0.
REQ-025 The handshake SHALL complete on a cycle with out_valid and out_ready both high; the next state is IDLE.
REQ-026 Latency from the start cycle T to out_valid SHALL be T+len+2 for len>0, and T+1 for len=0.
REQ-027 start outside IDLE, including the handshake cycle, SHALL be ignored.
REQ-028 step(a,x,w): sign-extend x and w to 2W bits and multiply; sign-extend a to 2W bits and shift left by FRAC_WIDTH; add the two, giving s.
REQ-029 The new acc value SHALL be {s[2W-1], s[2F+I-1:2F], s[2F-1:F]}; no rounding or saturation (wrap).
REQ-030 len > N_MAX SHALL be clamped to N_MAX.
REQ-031 rd_en SHALL be 0 outside RUN, and rd_addr SHALL be 0 when rd_en=0.

Reset
REQ-032 rst=1 SHALL immediately force IDLE, with acc, cnt, read-valid pipeline, rd_en, rd_addr, busy, out_valid and result all 0; this includes reset in mid-RUN or in OUT.
REQ-033 After reset release, the first start SHALL be processed normally, with no residual state from the aborted evaluation.

Structure
REQ-034 A shared package SHALL hold the default format constants (SIGN_BIT, INTE_WIDTH, FRAC_WIDTH) and the FSM state enum.
REQ-035 The step arithmetic SHALL be a combinational sub-module named neuron_mac_step; the FSM, counter and accumulator stay in neuron_seq_ctrl.

Verification
REQ-036 Dot product: x=[0x20,0x10], w=[0x20,0x40], bias=0x08, len=2, out_ready=1 -> reads at addresses 0 and 1, out_valid at T+4, result=0x48.
REQ-037 len=0: bias=0xF0, relu_en=0 -> out_valid at T+1, result=0xF0, no rd_en pulse.
REQ-038 ReLU: x=0x20, w=0xE0, bias=0, len=1 -> result=0xE0 with relu_en=0, and 0x00 with relu_en=1.
REQ-039 Wrap: x=0x60, w=0x60, bias=0, len=1 -> result=0x20.
REQ-040 Backpressure: out_ready=0 for 5 cycles with a start pulse during OUT -> result stable, start ignored, IDLE one cycle after out_ready=1.
REQ-041 Reset during RUN with len=8 at the third read -> all outputs 0 immediately; a following len=1 evaluation returns the correct value.
